fuel_tank: RTL and testbench

// - Game fuel timer. Feeds the top-level colour logic: fuel_width sizes the yellow HUD bar, time_out drives the game FSM to LOSE.
// - Burns fuel at a fixed tick rate while play is running, then scales the level to a bar width.
// - Raises a low-fuel warning and a sticky time-out.

---
 rtl/rally_pkg.sv | 16 +
 rtl/fuel_tank_if.sv | 25 ++
 rtl/fuel_scale_div.sv | 72 +++++++
 rtl/fuel_tank.sv | 134 +++++++++++++
 tb/tb_fuel_tank.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/rally_pkg.sv
// Shared rally game constants: clock rate, HUD fuel-bar geometry and fuel FSM encoding.
package rally_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned HUD_BAR_X  = 528;
    localparam int unsigned HUD_BAR_Y0 = 448;
    localparam int unsigned HUD_BAR_Y1 = 468;
    localparam int unsigned BAR_W      = 94;
    localparam int unsigned BAR_PIX_W  = 7;

    typedef enum logic {
        FUEL_BURN  = 1'b0,
        FUEL_EMPTY = 1'b1
    } fuel_state_e;

endpackage

// File: rtl/fuel_tank_if.sv
// Fuel tank control/status bundle between the game controller (master) and the tank (slave).
interface fuel_tank_if
    import rally_pkg::*;
#(
    parameter int unsigned FW = 10
);

    logic                 run;
    logic                 refuel;
    logic [FW-1:0]        fuel_level;
    logic [BAR_PIX_W-1:0] fuel_width;
    logic                 low_fuel;
    logic                 time_out;

    modport master (
        output run, refuel,
        input  fuel_level, fuel_width, low_fuel, time_out
    );

    modport slave (
        input  run, refuel,
        output fuel_level, fuel_width, low_fuel, time_out
    );

endinterface

// File: rtl/fuel_scale_div.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle; start restarts, abort drops.
module fuel_scale_div #(
    parameter int unsigned NW = 12,
    parameter int unsigned DW = 5,
    parameter int unsigned QW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic [QW-1:0] quo,
    output logic          done
);

    localparam int unsigned CW = $clog2(NW + 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [NW-1:0] acc_q;
    logic [DW-1:0] rem_q;
    logic [QW-1:0] quo_q;
    logic          done_q;

    logic [DW:0]   rem_sh;
    logic          ge;
    logic [DW-1:0] rem_d;
    logic [NW-1:0] acc_d;

    // Dividend bits shift out of acc MSB while quotient bits shift in at the LSB.
    always_comb begin
        rem_sh = {rem_q, acc_q[NW-1]};
        ge     = (rem_sh >= {1'b0, den});
        rem_d  = ge ? DW'(rem_sh - {1'b0, den}) : DW'(rem_sh);
        acc_d  = {acc_q[NW-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                busy_q <= 1'b0;
            end else if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(NW);
                acc_q  <= num;
                rem_q  <= '0;
            end else if (busy_q) begin
                acc_q <= acc_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    quo_q  <= acc_d[QW-1:0];
                end
            end
        end
    end

    assign quo  = quo_q;
    assign done = done_q;

endmodule

// File: rtl/fuel_tank.sv
// Game fuel timer: burns fuel on a prescaled tick, scales it to a HUD bar width, flags low fuel / time-out.
// Optional refuel pulses are built only when FUEL_REFUEL_EN is defined.
module fuel_tank #(
    parameter int unsigned CLK_HZ   = rally_pkg::CLK_HZ,
    parameter int unsigned TICK_HZ  = 10,
    parameter int unsigned FUEL_MAX = 1000,
    parameter int unsigned BAR_W    = rally_pkg::BAR_W,
    parameter int unsigned LOW_FUEL = 200
`ifdef FUEL_REFUEL_EN
    ,
    parameter int unsigned REFUEL_AMT = 150
`endif
) (
    input logic        clk,
    input logic        rst,
    fuel_tank_if.slave bus
);

    import rally_pkg::*;

    localparam int unsigned FW       = $clog2(FUEL_MAX + 1);
    localparam int unsigned WW       = BAR_PIX_W;
    localparam int unsigned NW       = FW + WW;
    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW       = $clog2(TICK_DIV);

    fuel_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] fuel_q,  fuel_d;
    logic [WW-1:0] width_q, width_d;
    logic          low_q;
    logic          tmo_q;

    logic          tick_c;
    logic          div_start_c;
    logic          div_abort_c;
    logic [NW-1:0] div_num_c;
    logic [WW-1:0] div_quo;
    logic          div_done;

`ifdef FUEL_REFUEL_EN
    localparam int unsigned SW = $clog2(FUEL_MAX + REFUEL_AMT + 1);
    logic [SW-1:0] sum_c;
`endif

    // Prescaler, fuel next-state and burn/empty transitions.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        fuel_d  = fuel_q;
        tick_c  = 1'b0;
`ifdef FUEL_REFUEL_EN
        sum_c   = '0;
`endif
        case (state_q)
            FUEL_BURN: begin
                if (bus.run) begin
                    tick_c  = (presc_q == PW'(TICK_DIV - 1));
                    presc_d = tick_c ? '0 : presc_q + PW'(1);
                end
`ifdef FUEL_REFUEL_EN
                // fuel_q >= 1 in BURN, so subtracting the tick cannot wrap.
                sum_c = SW'(fuel_q) + SW'(REFUEL_AMT) - SW'(tick_c);
                if (bus.refuel) begin
                    fuel_d = (sum_c > SW'(FUEL_MAX)) ? FW'(FUEL_MAX) : FW'(sum_c);
                end else if (tick_c) begin
                    fuel_d = fuel_q - FW'(1);
                end
`else
                if (tick_c) begin
                    fuel_d = fuel_q - FW'(1);
                end
`endif
                if (fuel_d == '0) begin
                    state_d = FUEL_EMPTY;
                end
            end
            default: begin
            end
        endcase
    end

    // Any nonzero fuel change (re)starts the scaler; a stale result racing a restart is dropped.
    always_comb begin
        div_start_c = (fuel_d != fuel_q) && (state_d == FUEL_BURN);
        div_abort_c = (state_d == FUEL_EMPTY);
        div_num_c   = NW'(fuel_d) * NW'(BAR_W);
        width_d     = width_q;
        if (state_d == FUEL_EMPTY) begin
            width_d = '0;
        end else if (div_done && !div_start_c) begin
            width_d = div_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FUEL_BURN;
            presc_q <= '0;
            fuel_q  <= FW'(FUEL_MAX);
            width_q <= WW'(BAR_W);
            low_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            fuel_q  <= fuel_d;
            width_q <= width_d;
            low_q   <= (fuel_d <= FW'(LOW_FUEL));
            tmo_q   <= (state_d == FUEL_EMPTY);
        end
    end

    fuel_scale_div #(
        .NW (NW),
        .DW (FW),
        .QW (WW)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_c),
        .abort (div_abort_c),
        .num   (div_num_c),
        .den   (FW'(FUEL_MAX)),
        .quo   (div_quo),
        .done  (div_done)
    );

    assign bus.fuel_level = fuel_q;
    assign bus.fuel_width = width_q;
    assign bus.low_fuel   = low_q;
    assign bus.time_out   = tmo_q;

endmodule

// File: tb/tb_fuel_tank.sv
// Bench for fuel_tank at CLK_HZ=100, TICK_HZ=10, FUEL_MAX=20, BAR_W=100, LOW_FUEL=5, REFUEL_AMT=8.
module tb_fuel_tank;

    localparam int unsigned FW = 5;
    localparam int FMAX = 20;
    localparam int BARW = 100;
    localparam int LOWF = 5;
`ifdef FUEL_REFUEL_EN
    localparam int FB = 20;   // fuel after the refuel pulse at 19
    localparam int W0 = 100;  // width published after that pulse
`else
    localparam int FB = 19;
    localparam int W0 = 95;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fuel_tank_if #(.FW(FW)) bus ();

    fuel_tank #(
        .CLK_HZ   (100),
        .TICK_HZ  (10),
        .FUEL_MAX (FMAX),
        .BAR_W    (BARW),
        .LOW_FUEL (LOWF)
`ifdef FUEL_REFUEL_EN
        ,
        .REFUEL_AMT (8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string name;
        bit    rst_n;
        bit    run;
        bit    refuel;
        int    cycles;
        int    fuel;
        int    width;
        bit    low;
        bit    tmo;
    } vec_t;

    typedef struct {
        string name;
        int    fuel;
        int    width;
        bit    low;
        bit    tmo;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int exp_w(int f);
        return (f * BARW) / FMAX;
    endfunction

    task automatic cmp(string name, string field, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s %s: got %0d, expected %0d at %0t", name, field, act, req, $time);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "fuel_level", int'(bus.fuel_level), e.fuel);
        cmp(e.name, "fuel_width", int'(bus.fuel_width), e.width);
        cmp(e.name, "low_fuel",   int'(bus.low_fuel),   int'(e.low));
        cmp(e.name, "time_out",   int'(bus.time_out),   int'(e.tmo));
    endtask

    // Drive one record for its cycle count, sample 1 time unit after the last edge.
    task automatic run_vec(vec_t v);
        exp_t e;
        rst        = v.rst_n;
        bus.run    = v.run;
        bus.refuel = v.refuel;
        e = '{v.name, v.fuel, v.width, v.low, v.tmo};
        sb.push_back(e);
        repeat (v.cycles) @(posedge clk);
        #1;
        bus.refuel = 1'b0;
        check_pop();
    endtask

    task automatic vec(string n, bit r, bit ru, bit rf, int c, int f, int w, bit l, bit t);
        vec_t v;
        v = '{n, r, ru, rf, c, f, w, l, t};
        run_vec(v);
    endtask

    initial begin
        rst        = 1'b0;
        bus.run    = 1'b0;
        bus.refuel = 1'b0;

        tbl.push_back('{"reset",        0, 0, 0,  2, 20,     100, 0, 0});
        tbl.push_back('{"pre_tick",     1, 1, 0,  9, 20,     100, 0, 0});
        tbl.push_back('{"first_tick",   1, 1, 0,  1, 19,     100, 0, 0});
        tbl.push_back('{"div_latency",  1, 0, 0, 12, 19,     100, 0, 0});
        tbl.push_back('{"div_publish",  1, 0, 0,  1, 19,      95, 0, 0});
        tbl.push_back('{"refuel_19",    1, 0, 1,  1, FB,      95, 0, 0});
        tbl.push_back('{"refuel_lat",   1, 0, 0, 12, FB,      95, 0, 0});
        tbl.push_back('{"refuel_pub",   1, 0, 0,  1, FB,      W0, 0, 0});
        tbl.push_back('{"run_part",     1, 1, 0,  4, FB,      W0, 0, 0});
        tbl.push_back('{"pause_37",     1, 0, 0, 37, FB,      W0, 0, 0});
        tbl.push_back('{"resume_5",     1, 1, 0,  5, FB,      W0, 0, 0});
        tbl.push_back('{"tick_at_10",   1, 1, 0,  1, FB - 1,  W0, 0, 0});
        tbl.push_back('{"fuel_6",       1, 1, 0, 10 * (FB - 7), 6, W0, 0, 0});
        tbl.push_back('{"fuel_5_low",   1, 1, 0, 10,  5,      W0, 1, 0});
        tbl.push_back('{"fuel_2",       1, 1, 0, 39,  2,      W0, 1, 0});
        tbl.push_back('{"fuel_1",       1, 1, 0,  1,  1,      W0, 1, 0});
        tbl.push_back('{"fuel_1_hold",  1, 1, 0,  9,  1,      W0, 1, 0});
        tbl.push_back('{"empty",        1, 1, 0,  1,  0,       0, 1, 1});
        tbl.push_back('{"empty_run",    1, 1, 0, 30,  0,       0, 1, 1});
        tbl.push_back('{"empty_refuel", 1, 1, 1,  1,  0,       0, 1, 1});
        tbl.push_back('{"empty_more",   1, 1, 0, 20,  0,       0, 1, 1});
        tbl.push_back('{"reset_empty",  0, 0, 0,  1, 20,     100, 0, 0});
        tbl.push_back('{"tick_again",   1, 1, 0, 10, 19,     100, 0, 0});
        tbl.push_back('{"div_busy",     1, 0, 0,  3, 19,     100, 0, 0});
        tbl.push_back('{"reset_in_div", 0, 0, 0,  1, 20,     100, 0, 0});
        tbl.push_back('{"no_stale_pub", 1, 0, 0, 20, 20,     100, 0, 0});

        foreach (tbl[i]) run_vec(tbl[i]);

        // Step fuel down one unit at a time, letting each division finish.
        for (int k = 19; k >= 1; k--) begin
            vec("sweep_tick", 1, 1, 0, 10, k, exp_w(k + 1), (k <= LOWF), 0);
            vec("sweep_wait", 1, 0, 0, 12, k, exp_w(k + 1), (k <= LOWF), 0);
            vec("sweep_pub",  1, 0, 0,  1, k, exp_w(k),     (k <= LOWF), 0);
        end
        vec("sweep_empty", 1, 1, 0, 10, 0, 0, 1, 1);

`ifdef FUEL_REFUEL_EN
        vec("r_reset",      0, 0, 0,   1, 20, 100, 0, 0);
        vec("r_fuel_15",    1, 1, 0,  50, 15, 100, 0, 0);
        vec("r_saturate",   1, 0, 1,   1, 20, 100, 0, 0);
        vec("r_sat_pub",    1, 0, 0,  13, 20, 100, 0, 0);
        vec("r_fuel_3",     1, 1, 0, 170,  3, 100, 1, 0);
        vec("r_pre_tick",   1, 1, 0,   9,  3, 100, 1, 0);
        vec("r_tick_ref",   1, 1, 1,   1, 10, 100, 0, 0);
        vec("r_pub_10",     1, 0, 0,  13, 10,  50, 0, 0);
        vec("r_fuel_1",     1, 1, 0,  90,  1,  50, 1, 0);
        vec("r_pre_tick1",  1, 1, 0,   9,  1,  50, 1, 0);
        vec("r_tick_ref1",  1, 1, 1,   1,  8,  50, 0, 0);
        vec("r_pub_8",      1, 0, 0,  13,  8,  40, 0, 0);
        // Refuel two cycles after a tick: the in-flight result for 10 must never appear.
        vec("r_reset2",     0, 0, 0,   1, 20, 100, 0, 0);
        vec("r_fuel_10",    1, 1, 0, 100, 10, 100, 0, 0);
        vec("r_gap",        1, 0, 0,   1, 10, 100, 0, 0);
        vec("r_busy_ref",   1, 0, 1,   1, 18, 100, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            vec("r_busy_hold", 1, 0, 0, 1, 18, 100, 0, 0);
        end
        vec("r_busy_pub",   1, 0, 0,   1, 18,  90, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
